// File: rtl/axil_cmd_master_if.sv
// Signal bundle between axil_cmd_master and its environment: command stream in, response stream
// out, and the AXI4-Lite master channels toward the register file.
interface axil_cmd_master_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  s_cmd_tvalid;
  logic                  s_cmd_tready;
  logic [63:0]           s_cmd_tdata;
  logic                  m_rsp_tvalid;
  logic                  m_rsp_tready;
  logic [39:0]           m_rsp_tdata;
  logic                  m_axi_awvalid;
  logic                  m_axi_awready;
  logic [ADDR_WIDTH-1:0] m_axi_awaddr;
  logic [2:0]            m_axi_awprot;
  logic                  m_axi_wvalid;
  logic                  m_axi_wready;
  logic [31:0]           m_axi_wdata;
  logic [3:0]            m_axi_wstrb;
  logic                  m_axi_bvalid;
  logic                  m_axi_bready;
  logic [1:0]            m_axi_bresp;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [2:0]            m_axi_arprot;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;
  logic [31:0]           m_axi_rdata;
  logic [1:0]            m_axi_rresp;

  modport master (
    input  s_cmd_tvalid, s_cmd_tdata, m_rsp_tready,
    input  m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp,
    input  m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp,
    output s_cmd_tready, m_rsp_tvalid, m_rsp_tdata,
    output m_axi_awvalid, m_axi_awaddr, m_axi_awprot, m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
    output m_axi_bready, m_axi_arvalid, m_axi_araddr, m_axi_arprot, m_axi_rready
  );

  modport slave (
    output s_cmd_tvalid, s_cmd_tdata, m_rsp_tready,
    output m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp,
    output m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp,
    input  s_cmd_tready, m_rsp_tvalid, m_rsp_tdata,
    input  m_axi_awvalid, m_axi_awaddr, m_axi_awprot, m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
    input  m_axi_bready, m_axi_arvalid, m_axi_araddr, m_axi_arprot, m_axi_rready
  );
endinterface

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master driven by a 64-bit command stream, one response per command.
// Define AXIL_CMD_MASTER_TIMEOUT_EN to add a watchdog that aborts a hung transaction.
module axil_cmd_master #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter logic [2:0]  PROT           = 3'b000,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  output logic              busy,
  axil_cmd_master_if.master bus
);

  typedef enum logic [2:0] {StIdle, StWrite, StWresp, StRead, StRdata, StRsp} state_e;

  state_e                r_state;
  logic                  r_cmd_tready;
  logic                  r_busy;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_bready;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_rsp_tvalid;
  logic [39:0]           r_rsp_tdata;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;

  logic [ADDR_WIDTH-1:0] w_cmd_addr;
  logic                  w_unused_bits;

  // Command address is 16 bits wide; the cast truncates or zero-extends to ADDR_WIDTH.
  assign w_cmd_addr    = ADDR_WIDTH'(bus.s_cmd_tdata[47:32]);
  assign w_unused_bits = ^{bus.s_cmd_tdata[62:60], bus.s_cmd_tdata[55:48],
                           (TIMEOUT_CYCLES == 32'd0)};

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] r_tmo_cnt;
  logic            w_wait_state;
  logic            w_is_write;

  assign w_wait_state = (r_state == StWrite) || (r_state == StWresp) ||
                        (r_state == StRead)  || (r_state == StRdata);
  assign w_is_write   = (r_state == StWrite) || (r_state == StWresp);
`endif

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state      <= StIdle;
      r_cmd_tready <= 1'b1;
      r_busy       <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_rsp_tvalid <= 1'b0;
      r_rsp_tdata  <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
      r_tmo_cnt    <= '0;
`endif
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.s_cmd_tvalid) begin
            r_addr       <= w_cmd_addr;
            r_wdata      <= bus.s_cmd_tdata[31:0];
            r_wstrb      <= bus.s_cmd_tdata[59:56];
            r_cmd_tready <= 1'b0;
            r_busy       <= 1'b1;
            if (bus.s_cmd_tdata[63]) begin
              r_state   <= StWrite;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
            end else begin
              r_state   <= StRead;
              r_arvalid <= 1'b1;
            end
          end
        end
        StWrite: begin
          if (bus.m_axi_awready) r_awvalid <= 1'b0;
          if (bus.m_axi_wready)  r_wvalid  <= 1'b0;
          // A channel already handshaken (valid low) counts as done.
          if ((!r_awvalid || bus.m_axi_awready) && (!r_wvalid || bus.m_axi_wready)) begin
            r_state  <= StWresp;
            r_bready <= 1'b1;
          end
        end
        StWresp: begin
          if (bus.m_axi_bvalid) begin
            r_bready     <= 1'b0;
            r_rsp_tvalid <= 1'b1;
            r_rsp_tdata  <= {1'b1, 5'b0, bus.m_axi_bresp, 32'h0};
            r_state      <= StRsp;
          end
        end
        StRead: begin
          if (bus.m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= StRdata;
          end
        end
        StRdata: begin
          if (bus.m_axi_rvalid) begin
            r_rready     <= 1'b0;
            r_rsp_tvalid <= 1'b1;
            r_rsp_tdata  <= {6'b0, bus.m_axi_rresp, bus.m_axi_rdata};
            r_state      <= StRsp;
          end
        end
        StRsp: begin
          if (bus.m_rsp_tready) begin
            r_rsp_tvalid <= 1'b0;
            r_cmd_tready <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= StIdle;
          end
        end
        default: begin
          r_state      <= StIdle;
          r_cmd_tready <= 1'b1;
          r_busy       <= 1'b0;
        end
      endcase

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
      // Watchdog overrides whatever the state logic decided this cycle.
      if (r_state == StIdle) begin
        r_tmo_cnt <= '0;
      end else if (w_wait_state) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
        if (r_tmo_cnt == CntW'(TIMEOUT_CYCLES - 1)) begin
          r_awvalid    <= 1'b0;
          r_wvalid     <= 1'b0;
          r_bready     <= 1'b0;
          r_arvalid    <= 1'b0;
          r_rready     <= 1'b0;
          r_rsp_tvalid <= 1'b1;
          r_rsp_tdata  <= {w_is_write, 4'b0, 1'b1, 2'b10, 32'h0};
          r_state      <= StRsp;
        end
      end
`endif
    end
  end

  assign busy              = r_busy;
  assign bus.s_cmd_tready  = r_cmd_tready;
  assign bus.m_rsp_tvalid  = r_rsp_tvalid;
  assign bus.m_rsp_tdata   = r_rsp_tdata;
  assign bus.m_axi_awvalid = r_awvalid;
  assign bus.m_axi_awaddr  = r_addr;
  assign bus.m_axi_awprot  = PROT;
  assign bus.m_axi_wvalid  = r_wvalid;
  assign bus.m_axi_wdata   = r_wdata;
  assign bus.m_axi_wstrb   = r_wstrb;
  assign bus.m_axi_bready  = r_bready;
  assign bus.m_axi_arvalid = r_arvalid;
  assign bus.m_axi_araddr  = r_addr;
  assign bus.m_axi_arprot  = PROT;
  assign bus.m_axi_rready  = r_rready;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: directed scenarios plus random commands checked against a word-array
// reference model. Define AXIL_CMD_MASTER_TIMEOUT_EN to also exercise the watchdog.
`timescale 1ns/1ps
module tb_axil_cmd_master;
  localparam int unsigned AW  = 16;
  localparam int unsigned TMO = 64;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  int unsigned cyc   = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axil_cmd_master_if #(.ADDR_WIDTH(AW)) bus ();

  axil_cmd_master #(
    .ADDR_WIDTH     (AW),
    .PROT           (3'b000),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .busy          (busy),
    .bus           (bus)
  );

  // Slave knobs and what the slave observed
  int unsigned aw_dly = 0, w_dly = 0, ar_dly = 0;
  bit          ar_never = 1'b0, r_ovr = 1'b0;
  logic [31:0] r_ovr_data = '0;
  logic [1:0]  bresp_cfg = '0, rresp_cfg = '0;
  int unsigned aw_hs_cyc = 0, w_hs_cyc = 0, ar_hs_cyc = 0, b_cnt = 0, aw_hi = 0, w_hi = 0;
  bit          aw_unstable = 1'b0;
  logic [15:0] aw_first = '0, got_awaddr = '0, got_araddr = '0;
  logic [31:0] got_wdata = '0;
  logic [3:0]  got_wstrb = '0;
  logic [31:0] smem    [16];
  logic [31:0] ref_mem [16];

  function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~m) | (d & m);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Behavioural AXI4-Lite slave: decides at negedge, updates #1 after posedge
  initial begin : slave
    bit hs_aw, hs_w, hs_b, hs_ar, hs_r, got_aw, got_w;
    int unsigned aw_seen, w_seen, ar_seen;
    got_aw = 0; got_w = 0; aw_seen = 0; w_seen = 0; ar_seen = 0;
    bus.m_axi_awready = 0; bus.m_axi_wready = 0; bus.m_axi_bvalid = 0; bus.m_axi_bresp = 0;
    bus.m_axi_arready = 0; bus.m_axi_rvalid = 0; bus.m_axi_rdata = 0; bus.m_axi_rresp = 0;
    forever begin
      @(negedge clk);
      hs_aw = bus.m_axi_awvalid && bus.m_axi_awready;
      hs_w  = bus.m_axi_wvalid && bus.m_axi_wready;
      hs_b  = bus.m_axi_bvalid && bus.m_axi_bready;
      hs_ar = bus.m_axi_arvalid && bus.m_axi_arready;
      hs_r  = bus.m_axi_rvalid && bus.m_axi_rready;
      if (bus.m_axi_awvalid) begin
        if (aw_hi == 0) aw_first = bus.m_axi_awaddr;
        else if (bus.m_axi_awaddr !== aw_first) aw_unstable = 1'b1;
        aw_hi++;
      end
      if (bus.m_axi_wvalid) w_hi++;
      if (hs_aw) begin aw_hs_cyc = cyc; got_awaddr = bus.m_axi_awaddr; end
      if (hs_w) begin w_hs_cyc = cyc; got_wdata = bus.m_axi_wdata; got_wstrb = bus.m_axi_wstrb; end
      if (hs_ar) begin ar_hs_cyc = cyc; got_araddr = bus.m_axi_araddr; end
      @(posedge clk); #1;
      if (!rst_n) begin
        got_aw = 0; got_w = 0; aw_seen = 0; w_seen = 0; ar_seen = 0;
        bus.m_axi_awready = 0; bus.m_axi_wready = 0; bus.m_axi_bvalid = 0;
        bus.m_axi_arready = 0; bus.m_axi_rvalid = 0;
      end else begin
        if (hs_aw) got_aw = 1;
        if (hs_w)  got_w  = 1;
        if (hs_b) begin bus.m_axi_bvalid = 0; b_cnt++; end
        if (got_aw && got_w) begin
          for (int b = 0; b < 4; b++)
            if (got_wstrb[b]) smem[got_awaddr[5:2]][8*b +: 8] = got_wdata[8*b +: 8];
          bus.m_axi_bvalid = 1; bus.m_axi_bresp = bresp_cfg;
          got_aw = 0; got_w = 0;
        end
        if (hs_r) bus.m_axi_rvalid = 0;
        if (hs_ar) begin
          bus.m_axi_rvalid = 1; bus.m_axi_rresp = rresp_cfg;
          bus.m_axi_rdata  = r_ovr ? r_ovr_data : smem[got_araddr[5:2]];
        end
        if (!bus.m_axi_awvalid) aw_seen = 0;
        if (!bus.m_axi_wvalid)  w_seen  = 0;
        if (!bus.m_axi_arvalid) ar_seen = 0;
        bus.m_axi_awready = bus.m_axi_awvalid && (aw_seen >= aw_dly);
        bus.m_axi_wready  = bus.m_axi_wvalid && (w_seen >= w_dly);
        bus.m_axi_arready = bus.m_axi_arvalid && !ar_never && (ar_seen >= ar_dly);
        if (bus.m_axi_awvalid && !bus.m_axi_awready) aw_seen++;
        if (bus.m_axi_wvalid && !bus.m_axi_wready)   w_seen++;
        if (bus.m_axi_arvalid && !bus.m_axi_arready) ar_seen++;
      end
    end
  end

  task automatic send_cmd(input bit wr, input logic [3:0] strb, input logic [15:0] addr,
                          input logic [31:0] data, output int unsigned acc);
    int unsigned k = 0;
    logic [2:0]  j3;
    logic [7:0]  j8;
    j3 = 3'($urandom);
    j8 = 8'($urandom);
    @(posedge clk); #1;
    bus.s_cmd_tvalid = 1'b1;
    bus.s_cmd_tdata  = {wr, j3, strb, j8, addr, data};
    @(negedge clk);
    while (bus.s_cmd_tready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    acc = cyc;
    check("cmd_tready", {63'b0, bus.s_cmd_tready}, 64'd1);
    @(posedge clk); #1;
    bus.s_cmd_tvalid = 1'b0;
    bus.s_cmd_tdata  = {$urandom, $urandom};
  endtask

  task automatic wait_rsp(input string tag, input logic [39:0] exp, input int hold,
                          input int unsigned bound, input int unsigned acc,
                          output int unsigned lat);
    int unsigned k = 0;
    bus.m_rsp_tready = (hold == 0);
    while (bus.m_rsp_tvalid !== 1'b1 && k < bound) begin @(negedge clk); k++; end
    lat = cyc - acc;
    check({tag, "_rsp_valid"}, {63'b0, bus.m_rsp_tvalid}, 64'd1);
    check({tag, "_rsp_data"}, {24'b0, bus.m_rsp_tdata}, {24'b0, exp});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_data"}, {24'b0, bus.m_rsp_tdata}, {24'b0, exp});
      check({tag, "_hold_quiet"}, {59'b0, bus.m_rsp_tvalid, bus.s_cmd_tready,
            bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid}, 64'b10000);
    end
    bus.m_rsp_tready = 1'b1;
    @(negedge clk);
    check({tag, "_idle"}, {61'b0, bus.m_rsp_tvalid, bus.s_cmd_tready, busy}, 64'b010);
  endtask

  initial begin : main
    int unsigned acc, lat, b0, idx, exp_lat;
    int          hold;
    bit          wr;
    logic [3:0]  strb;
    logic [15:0] addr;
    logic [31:0] data;
    logic [39:0] exp;
    for (int i = 0; i < 16; i++) begin smem[i] = '0; ref_mem[i] = '0; end
    bus.s_cmd_tvalid = 1'b0;
    bus.s_cmd_tdata  = '0;
    bus.m_rsp_tready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready_busy", {62'b0, bus.s_cmd_tready, busy}, 64'b10);
    check("rst_valids", {58'b0, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid,
          bus.m_axi_bready, bus.m_axi_rready, bus.m_rsp_tvalid}, 64'd0);
    check("rst_data", {bus.m_rsp_tdata, bus.m_axi_awaddr, bus.m_axi_wstrb, 4'b0},
          64'd0);
    check("rst_wdata", {32'b0, bus.m_axi_wdata}, 64'd0);
    rst_n = 1'b1;

    // 1: zero-wait write, latency N+1 / N+3
    b0 = b_cnt;
    send_cmd(1'b1, 4'hF, 16'h0004, 32'hDEADBEEF, acc);
    ref_mem[1] = apply_strb(ref_mem[1], 32'hDEADBEEF, 4'hF);
    wait_rsp("s1", 40'h80_0000_0000, 0, 40, acc, lat);
    check("s1_lat", 64'(lat), 64'd3);
    check("s1_aw_cyc", 64'(aw_hs_cyc), 64'(acc + 1));
    check("s1_w_cyc", 64'(w_hs_cyc), 64'(acc + 1));
    check("s1_awaddr", 64'(got_awaddr), 64'h0004);
    check("s1_wdata", 64'(got_wdata), 64'hDEADBEEF);
    check("s1_bcnt", 64'(b_cnt - b0), 64'd1);

    // 2: read back
    send_cmd(1'b0, 4'h0, 16'h0004, 32'h0, acc);
    wait_rsp("s2", {8'h00, ref_mem[1]}, 0, 40, acc, lat);
    check("s2_lat", 64'(lat), 64'd3);
    check("s2_ar_cyc", 64'(ar_hs_cyc), 64'(acc + 1));
    check("s2_araddr", 64'(got_araddr), 64'h0004);

    // 3: awready delayed 3 cycles, wready immediate
    aw_dly = 3; aw_hi = 0; w_hi = 0; aw_unstable = 0; b0 = b_cnt;
    send_cmd(1'b1, 4'h3, 16'h0008, 32'hCAFE_F00D, acc);
    ref_mem[2] = apply_strb(ref_mem[2], 32'hCAFE_F00D, 4'h3);
    wait_rsp("s3", 40'h80_0000_0000, 0, 40, acc, lat);
    check("s3_aw_hi", 64'(aw_hi), 64'd4);
    check("s3_w_hi", 64'(w_hi), 64'd1);
    check("s3_aw_stable", {63'b0, aw_unstable}, 64'd0);
    check("s3_bcnt", 64'(b_cnt - b0), 64'd1);
    check("s3_lat", 64'(lat), 64'd6);
    aw_dly = 0;

    // 4: response back-pressure for 5 cycles
    send_cmd(1'b0, 4'h0, 16'h0008, 32'h0, acc);
    wait_rsp("s4", {8'h00, ref_mem[2]}, 5, 40, acc, lat);

    // 6a: error response passed through
    rresp_cfg = 2'b10; r_ovr = 1'b1; r_ovr_data = 32'h1234_5678;
    send_cmd(1'b0, 4'h0, 16'h000C, 32'h0, acc);
    wait_rsp("s6", {8'h02, 32'h1234_5678}, 0, 40, acc, lat);
    rresp_cfg = 2'b00; r_ovr = 1'b0;

    // Random commands against the reference model
    for (int t = 0; t < 24; t++) begin
      wr   = 1'($urandom_range(0, 1));
      idx  = $urandom_range(0, 15);
      addr = {10'($urandom_range(0, 1023)), idx[3:0], 2'b00};
      data = $urandom;
      strb = 4'($urandom_range(0, 15));
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
      bresp_cfg = 2'($urandom_range(0, 3)); rresp_cfg = 2'($urandom_range(0, 3));
      hold = $urandom_range(0, 2);
      b0 = b_cnt;
      if (wr) begin
        exp = {1'b1, 5'b0, bresp_cfg, 32'h0};
        exp_lat = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly);
        ref_mem[idx] = apply_strb(ref_mem[idx], data, strb);
      end else begin
        exp = {6'b0, rresp_cfg, ref_mem[idx]};
        exp_lat = 3 + ar_dly;
      end
      send_cmd(wr, strb, addr, data, acc);
      wait_rsp("rnd", exp, hold, 40, acc, lat);
      check("rnd_lat", 64'(lat), 64'(exp_lat));
      if (wr) begin
        check("rnd_aw", {16'b0, got_awaddr, got_wdata}, {16'b0, addr, data});
        check("rnd_strb_b", {got_wstrb, 60'(b_cnt - b0)}, {strb, 60'd1});
      end else begin
        check("rnd_ar", 64'(got_araddr), 64'(addr));
      end
    end
    aw_dly = 0; w_dly = 0; ar_dly = 0; bresp_cfg = 0; rresp_cfg = 0;

    // 5: reset while READ is waiting on arready
    ar_never = 1'b1;
    send_cmd(1'b0, 4'h0, 16'h0010, 32'h0, acc);
    @(negedge clk);
    check("s5_arvalid_pre", {63'b0, bus.m_axi_arvalid}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("s5_reset_drop", {60'b0, bus.m_axi_arvalid, bus.m_axi_rready, bus.m_rsp_tvalid, busy},
          64'd0);
    ar_never = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("s5_after", {62'b0, bus.s_cmd_tready, busy}, 64'b10);
    send_cmd(1'b0, 4'h0, 16'h0004, 32'h0, acc);
    wait_rsp("s5_recover", {8'h00, ref_mem[1]}, 0, 40, acc, lat);

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    // 6b: slave never accepts the read address
    ar_never = 1'b1;
    send_cmd(1'b0, 4'h0, 16'h0014, 32'h0, acc);
    wait_rsp("s6_timeout", 40'h06_0000_0000, 0, TMO + 20, acc, lat);
    check("s6_to_lat", {63'b0, (lat >= TMO) && (lat <= TMO + 2)}, 64'd1);
    ar_never = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
